hd_mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (1-cycle read, zero output when not reading) between NUM_REQ requesters in the HD accelerator (encoder, accumulator, classifier).
- Owns the RAM control pins (address, data in, cs, we, oe) and clears the whole RAM to zero after reset or on command.
- Routes read data back to the requester that issued the read.

---
 rtl/hd_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_hd_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hd_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NUM_REQ requesters.
// Clears the RAM after reset or on clear_start, then serves one command per cycle.
module hd_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             clear_start,
  output logic                             init_done,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  output logic                             mem_cs,
  output logic                             mem_we,
  output logic                             mem_oe,
  input  logic [DATA_WIDTH-1:0]            mem_data_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        clr_cnt;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    s1_valid;
  logic [IDX_W-1:0]        s1_idx;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_cnt == CNT_W'(RAM_DEPTH - 1)) state_next = ST_RUN;
      ST_RUN:   if (clear_start) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    int unsigned cand;
    grant_idx   = ptr;
    grant_found = 1'b0;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Output/grant logic; clear_start pre-empts any request in the same cycle
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    sel_we    = req_we[grant_idx];
    sel_addr  = req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    if (state == ST_RUN && !clear_start && grant_found) begin
      req_ready[grant_idx] = 1'b1;
      accept               = 1'b1;
    end
  end

  // RAM bus, clear counter, pointer and read-tag pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt     <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      mem_address <= '0;
      mem_data_in <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      rsp_valid   <= '0;
      init_done   <= 1'b0;
    end else begin
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      init_done <= (state_next == ST_RUN);
      s1_valid  <= accept && !sel_we;
      s1_idx    <= grant_idx;
      rsp_valid <= s1_valid ? (NUM_REQ'(1) << s1_idx) : '0;
      if (state == ST_CLEAR) begin
        mem_cs      <= 1'b1;
        mem_we      <= 1'b1;
        mem_address <= clr_cnt[ADDR_WIDTH-1:0];
        mem_data_in <= '0;
        clr_cnt     <= clr_cnt + CNT_W'(1);
      end else begin
        if (clear_start) clr_cnt <= '0;
        if (accept) begin
          mem_cs      <= 1'b1;
          mem_we      <= sel_we;
          mem_oe      <= !sel_we;
          mem_address <= sel_addr;
          mem_data_in <= sel_we ? sel_wdata : '0;
          ptr         <= grant_idx;
        end
      end
    end
  end

  // RAM drives zero when not reading, so passthrough is safe
  assign rsp_rdata = mem_data_out;

endmodule

// File: tb/tb_hd_mem_arbiter.sv
// Directed bench for hd_mem_arbiter with a behavioural single-port RAM.
module tb_hd_mem_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata;
  logic              clear_start, init_done;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_in, mem_data_out;
  logic              mem_cs, mem_we, mem_oe;
  logic [DW-1:0]     ram [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd_mem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_start(clear_start),
    .init_done(init_done), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_data_out(mem_data_out)
  );

  // Single-port RAM: 1-cycle read, zero output when not reading
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_address] <= mem_data_in;
    mem_data_out <= (mem_cs && mem_oe && !mem_we) ? ram[mem_address] : '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic bus_chk(input string tag, input logic cs, input logic we, input logic oe,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_cs"}, mem_cs, cs);
    chk({tag, "_we"}, mem_we, we);
    chk({tag, "_oe"}, mem_oe, oe);
    chk({tag, "_addr"}, mem_address, a);
    chk({tag, "_din"}, mem_data_in, d);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_start = 1'b0;
    clr_reqs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);

    // Initial clear: cycles 0..256
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("clr_ready", req_ready, 0);
      chk("clr_init", init_done, k >= 256);
      bus_chk("clr", k >= 1, k >= 1, 1'b0, (k >= 1) ? AW'(k - 1) : '0, '0);
    end

    // Write then read-after-write from requester 2
    @(negedge clk); set_req(2, 1'b1, 8'h10, 32'hDEADBEEF); #1;
    chk("wr_ready", req_ready, 4'b0100);
    chk("wr_idle_cs", mem_cs, 0);
    @(negedge clk); set_req(2, 1'b0, 8'h10, '0); #1;
    chk("rd_ready", req_ready, 4'b0100);
    bus_chk("wr_bus", 1, 1, 0, 8'h10, 32'hDEADBEEF);
    @(negedge clk); clr_reqs(); #1;
    chk("raw_ready", req_ready, 0);
    bus_chk("rd_bus", 1, 0, 1, 8'h10, '0);
    chk("raw_rsp_early", rsp_valid, 0);
    @(negedge clk); #1;
    chk("raw_rsp", rsp_valid, 4'b0100);
    chk("raw_data", rsp_rdata, 32'hDEADBEEF);
    chk("idle_cs", mem_cs, 0);
    chk("idle_addr_hold", mem_address, 8'h10);
    @(negedge clk); #1;
    chk("raw_rsp_once", rsp_valid, 0);
    chk("raw_data_zero", rsp_rdata, 0);

    // Requester 1 reads a cleared address
    @(negedge clk); set_req(1, 1'b0, 8'h77, '0); #1;
    chk("r1_ready", req_ready, 4'b0010);
    @(negedge clk); clr_reqs();
    @(negedge clk); #1;
    chk("r1_rsp", rsp_valid, 4'b0010);
    chk("r1_data", rsp_rdata, 0);

    // Requester 3 fills 0x20..0x23, leaving the pointer at 3
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_req(3, 1'b1, AW'(8'h20 + i), 32'h11110000 + i); #1;
      chk("fill_ready", req_ready, 4'b1000);
    end
    @(negedge clk); clr_reqs();

    // All four reading: grants 0,1,2,3,0,1, responses two cycles later
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(8'h20 + i), '0);
      else clr_reqs();
      #1;
      if (k < 6) chk("rr_ready", req_ready, NR'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_rsp", rsp_valid, NR'(1) << ((k - 2) % 4));
        chk("rr_data", rsp_rdata, 32'h11110000 + ((k - 2) % 4));
      end
    end

    // Read in flight survives clear_start; clear_start beats a request
    @(negedge clk); set_req(3, 1'b0, 8'h23, '0); #1;
    chk("cs_r3_ready", req_ready, 4'b1000);
    @(negedge clk); clr_reqs(); set_req(0, 1'b0, 8'h20, '0); clear_start = 1'b1; #1;
    chk("cs_ready_blocked", req_ready, 0);
    chk("cs_init_still", init_done, 1);
    @(negedge clk); clear_start = 1'b0; #1;
    chk("cs_rsp", rsp_valid, 4'b1000);
    chk("cs_data", rsp_rdata, 32'h11110003);
    chk("cs_ready_clear", req_ready, 0);
    chk("cs_init_low", init_done, 0);
    for (int j = 1; j <= 256; j++) begin
      @(negedge clk);
      clear_start = (j == 100);
      #1;
      chk("cs_init", init_done, j == 256);
      chk("cs_ready", req_ready, (j == 256) ? 4'b0001 : 4'b0000);
      if (j == 1)   bus_chk("cs_first", 1, 1, 0, 8'h00, '0);
      if (j == 101) chk("cs_no_restart", mem_address, 8'd100);
    end
    @(negedge clk); clr_reqs(); clear_start = 1'b0;
    @(negedge clk); #1;
    chk("cs_post_rsp", rsp_valid, 4'b0001);
    chk("cs_post_data", rsp_rdata, 0);

    // Reset mid-clear at counter 100
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 100; k++) @(negedge clk);
    #1;
    chk("mid_addr", mem_address, 8'd99);
    reset = 1'b1;
    @(negedge clk); #1;
    bus_chk("mid_rst", 0, 0, 0, 8'h00, '0);
    chk("mid_rst_init", init_done, 0);
    reset = 1'b0;
    for (int j = 0; j <= 256; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk("rerun_init", init_done, j == 256);
      if (j == 1) bus_chk("rerun_first", 1, 1, 0, 8'h00, '0);
    end

    // Reset with a read in flight drops the response
    @(negedge clk); set_req(0, 1'b0, 8'h20, '0); #1;
    chk("inflight_ready", req_ready, 4'b0001);
    @(negedge clk); clr_reqs(); reset = 1'b1;
    @(negedge clk); #1;
    chk("inflight_rsp0", rsp_valid, 0);
    chk("inflight_cs", mem_cs, 0);
    @(negedge clk); #1;
    chk("inflight_rsp1", rsp_valid, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("inflight_rsp2", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
